npn_canonizer: RTL and testbench
================================

NPN_CANONIZER -- requirements
Module: npn_canonizer

Interface
REQ-001 SHALL have parameter TT_W, default 16: truth-table width for 4 inputs; only the value 16 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_tt is valid.
REQ-005 SHALL have port in_ready  output  1  block idle and accepting a truth table.
REQ-006 SHALL have port in_tt  input  16  truth table f; bit k = f(x3..x0 = k).
REQ-007 SHALL have port out_valid  output  1  result is valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port out_tt  output  16  NPN-canonical truth table.
REQ-010 SHALL have port out_perm  output  5  permutation index 0..23 of the winning transform.
REQ-011 SHALL have port out_imask  output  4  input-negation mask of the winning transform.
REQ-012 SHALL have port out_oneg  output  1  output negation of the winning transform.

Function
REQ-013 SHALL be an FSM with states IDLE, SCAN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL capture in_tt and move IDLE->SCAN on in_valid&&in_ready.
REQ-015 SHALL in SCAN evaluate exactly one (p,m) candidate per cycle: p outer 0..23, m inner 0..15, for 384 cycles in total.
REQ-016 SHALL index permutations lexicographically over orderings of {0,1,2,3}; candidate g(y) = f(x), where x[perm[i]] = y[i]^m[i].
REQ-017 SHALL form the candidate cost as min(g,~g), unsigned; select ~g (oneg=1) only if ~g < g strictly.
REQ-018 SHALL update the best candidate only on strictly smaller cost, so the first minimum in iteration order wins; the best candidate is seeded by the (0,0) candidate.
REQ-019 SHALL go SCAN->DONE after candidate (23,15); out_valid rises exactly 385 cycles after the accepting edge.
REQ-020 SHALL hold all outputs stable in DONE until out_valid&&out_ready, then return to IDLE; in_ready is not asserted in the same cycle as out_valid.
REQ-021 SHALL ignore in_valid outside IDLE; in_tt changes during SCAN have no effect.

Reset
REQ-022 SHALL on rst, at any time including mid-SCAN or in DONE, force state=IDLE, counters=0 and best=0xFFFF, with out_tt/out_perm/out_imask/out_oneg=0, out_valid=0 and in_ready=1 after the first clock edge.

Configuration
REQ-023 SHALL with NPN_CANON_TRANSFORM_EN defined track and drive out_perm, out_imask and out_oneg per REQ-017/018.
REQ-024 SHALL with NPN_CANON_TRANSFORM_EN undefined keep those ports present but tied to 0 and omit their tracking registers; out_tt and timing are unchanged.

Structure
REQ-025 SHALL place in package npn_pkg: the 16-bit tt_t typedef, the 24-entry permutation LUT constant, NUM_PERM=24, NUM_MASK=16, and the state enum.
REQ-026 SHALL implement the truth-table transform (tt, perm, mask -> g) as a combinational sub-module npn_tt_xform.

Verification
REQ-027 SHALL verify: in_tt=0x0000 -> out_tt=0x0000, perm=0, imask=0, oneg=0, out_valid 385 cycles after acceptance.
REQ-028 SHALL verify: in_tt=0xFFFF -> out_tt=0x0000, perm=0, imask=0, oneg=1.
REQ-029 SHALL verify: in_tt=0x8000 (AND4) -> out_tt=0x0001, perm=0, imask=0xF, oneg=0.
REQ-030 SHALL verify: in_tt=0xAAAA, 0xCCCC, 0xF0F0 and 0xFF00 -> out_tt=0x00FF in each case.
REQ-031 SHALL verify: out_ready held low 20 cycles in DONE -> outputs stable, in_ready=0, a concurrent in_valid is ignored.
REQ-032 SHALL verify: rst pulse at SCAN cycle 100 -> IDLE with zeroed outputs; a new in_tt=0x0001 then gives out_tt=0x0001.

Source files
------------

// File: rtl/npn_pkg.sv
// Shared types and constants for the 4-input NPN canonizer.
//   tt_t      : 16-bit truth table, bit k = f(x3..x0 = k)
//   PERM_LUT  : the 24 orderings of {0,1,2,3} in lexicographic order.
//               Nibble i (counting from the MS nibble) holds perm[i].
//   NUM_PERM / NUM_MASK : permutation and input-negation mask counts
//   state_t   : canonizer control states
package npn_pkg;

  typedef logic [15:0] tt_t;

  localparam int unsigned NUM_PERM = 24;
  localparam int unsigned NUM_MASK = 16;

  localparam logic [15:0] PERM_LUT [NUM_PERM] = '{
    16'h0123, 16'h0132, 16'h0213, 16'h0231, 16'h0312, 16'h0321,
    16'h1023, 16'h1032, 16'h1203, 16'h1230, 16'h1302, 16'h1320,
    16'h2013, 16'h2031, 16'h2103, 16'h2130, 16'h2301, 16'h2310,
    16'h3012, 16'h3021, 16'h3102, 16'h3120, 16'h3201, 16'h3210
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/npn_tt_xform.sv
// Combinational truth-table transform for one NPN candidate.
//   tt   : source truth table f
//   perm : permutation index 0..23 into PERM_LUT (out-of-range -> identity)
//   mask : input-negation mask m
//   g    : transformed table, g(y) = f(x) with x[perm[i]] = y[i] ^ m[i]
module npn_tt_xform
  import npn_pkg::*;
(
  input  tt_t        tt,
  input  logic [4:0] perm,
  input  logic [3:0] mask,
  output tt_t        g
);

  always_comb begin
    logic [15:0] ent;
    logic [1:0]  pos;
    logic [3:0]  x;
    ent = (perm < 5'(NUM_PERM)) ? PERM_LUT[perm] : PERM_LUT[0];
    g   = '0;
    for (int unsigned y = 0; y < 16; y++) begin
      x = '0;
      for (int unsigned i = 0; i < 4; i++) begin
        pos    = ent[(3 - i) * 4 +: 2];
        x[pos] = y[i] ^ mask[i];
      end
      g[y] = tt[x];
    end
  end

endmodule

// File: rtl/npn_canonizer.sv
// 4-input NPN canonizer: exhaustively scans all 24 permutations x 16 input
// negation masks (one candidate per cycle, 384 cycles) and returns the
// smallest min(g,~g) truth table, first minimum in scan order winning.
// Optional feature macro: NPN_CANON_TRANSFORM_EN -- when defined, the
// winning permutation / input mask / output negation are reported; when
// undefined those ports are tied to 0.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready/in_tt       : truth-table input handshake
//   out_valid/out_ready/out_tt    : canonical result handshake
//   out_perm/out_imask/out_oneg   : winning transform
module npn_canonizer
  import npn_pkg::*;
#(
  parameter int unsigned TT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TT_W-1:0] in_tt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TT_W-1:0] out_tt,
  output logic [4:0]      out_perm,
  output logic [3:0]      out_imask,
  output logic            out_oneg
);

  localparam logic [8:0] LAST_CAND = 9'd383;
  localparam logic [8:0] SCAN_END  = 9'd384;

  state_t     state, state_nxt;
  tt_t        tt_q;
  logic [8:0] idx;       // {perm, mask} of the candidate being transformed
  tt_t        xf_g;

  // One register stage between transform and compare; this is what puts
  // out_valid 385 cycles after acceptance rather than 384.
  tt_t        cand_g;
  logic [8:0] cand_idx;
  logic       cand_vld;

  tt_t        best_tt;
  tt_t        cand_cost;
  logic       cand_neg;
  logic       upd;
  logic       last_cmp;

  npn_tt_xform u_xform (
    .tt   (tt_q),
    .perm (idx[8:4]),
    .mask (idx[3:0]),
    .g    (xf_g)
  );

  always_comb begin
    cand_neg  = (~cand_g < cand_g);
    cand_cost = cand_neg ? ~cand_g : cand_g;
    // Candidate 0 always seeds the best; later ones need a strict improvement.
    upd       = cand_vld && ((cand_idx == '0) || (cand_cost < best_tt));
    last_cmp  = cand_vld && (cand_idx == LAST_CAND);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SCAN;
      SCAN:    if (last_cmp)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_q     <= '0;
      idx      <= '0;
      cand_g   <= '0;
      cand_idx <= '0;
      cand_vld <= 1'b0;
      best_tt  <= '1;
      out_tt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tt_q     <= tt_t'(in_tt);
            idx      <= '0;
            cand_vld <= 1'b0;
          end
        end
        SCAN: begin
          if (idx < SCAN_END) begin
            cand_g   <= xf_g;
            cand_idx <= idx;
            cand_vld <= 1'b1;
            idx      <= idx + 9'd1;
          end else begin
            cand_vld <= 1'b0;
          end
          if (upd) best_tt <= cand_cost;
          if (last_cmp) out_tt <= upd ? cand_cost : best_tt;
        end
        default: ;
      endcase
    end
  end

`ifdef NPN_CANON_TRANSFORM_EN
  logic [4:0] best_perm;
  logic [3:0] best_mask;
  logic       best_oneg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_perm <= '0;
      best_mask <= '0;
      best_oneg <= 1'b0;
      out_perm  <= '0;
      out_imask <= '0;
      out_oneg  <= 1'b0;
    end else if (state == SCAN) begin
      if (upd) begin
        best_perm <= cand_idx[8:4];
        best_mask <= cand_idx[3:0];
        best_oneg <= cand_neg;
      end
      if (last_cmp) begin
        out_perm  <= upd ? cand_idx[8:4] : best_perm;
        out_imask <= upd ? cand_idx[3:0] : best_mask;
        out_oneg  <= upd ? cand_neg      : best_oneg;
      end
    end
  end
`else
  assign out_perm  = '0;
  assign out_imask = '0;
  assign out_oneg  = 1'b0;
`endif

endmodule

// File: tb/tb_npn_canonizer.sv
// Self-checking bench for npn_canonizer: directed cases plus random truth
// tables compared against a brute-force NPN reference model.
module tb_npn_canonizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_tt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_tt;
  logic [4:0]  out_perm;
  logic [3:0]  out_imask;
  logic        out_oneg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  npn_canonizer #(.TT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tt     (in_tt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tt    (out_tt),
    .out_perm  (out_perm),
    .out_imask (out_imask),
    .out_oneg  (out_oneg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Enumerate orderings lexicographically, try every mask, keep the first
  // strictly smallest min(g, ~g).
  function automatic void ref_canon(input logic [15:0] f, output logic [15:0] bt,
                                    output int bp, output logic [3:0] bm, output logic bn);
    int          ord [4];
    int          pidx;
    bit          first;
    logic [15:0] g, cost;
    logic [3:0]  x;
    logic        neg;
    pidx = 0; first = 1'b1; bt = '0; bp = 0; bm = '0; bn = 1'b0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        if (b == a) continue;
        for (int c = 0; c < 4; c++) begin
          if (c == a || c == b) continue;
          ord = '{a, b, c, 6 - a - b - c};
          for (int m = 0; m < 16; m++) begin
            for (int y = 0; y < 16; y++) begin
              x = '0;
              for (int i = 0; i < 4; i++) x[ord[i]] = y[i] ^ m[i];
              g[y] = f[x];
            end
            neg  = (~g < g);
            cost = neg ? ~g : g;
            if (first || cost < bt) begin
              first = 1'b0; bt = cost; bp = pidx; bm = m[3:0]; bn = neg;
            end
          end
          pidx++;
        end
      end
  endfunction

  task automatic run_one(input logic [15:0] f, input logic [15:0] e_tt, input int e_p,
                         input logic [3:0] e_m, input logic e_n, input bit stall);
    int          n;
    logic [15:0] hold_tt;
    logic [4:0]  hold_p;
    logic [3:0]  hold_m;
    logic        hold_n;
`ifndef NPN_CANON_TRANSFORM_EN
    e_p = 0; e_m = '0; e_n = 1'b0;
`endif
    n = 0;
    while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_tt    = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 1000) begin
      in_tt    = 16'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'd385);
    check("out_tt",    32'(out_tt),    32'(e_tt));
    check("out_perm",  32'(out_perm),  32'(e_p));
    check("out_imask", 32'(out_imask), 32'(e_m));
    check("out_oneg",  32'(out_oneg),  32'(e_n));
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    if (stall) begin
      hold_tt = out_tt; hold_p = out_perm; hold_m = out_imask; hold_n = out_oneg;
      in_valid = 1'b1;
      in_tt    = ~f;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_ready", 32'(in_ready), 32'd0);
        check("stall_tt", 32'({out_tt, out_perm, out_imask, out_oneg}),
              32'({hold_tt, hold_p, hold_m, hold_n}));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_outputs"},   32'({out_tt, out_perm, out_imask, out_oneg}), 32'd0);
  endtask

  initial begin
    logic [15:0] f, bt;
    int          bp;
    logic [3:0]  bm;
    logic        bn;
    logic [15:0] fam [4];

    rst = 1'b1; in_valid = 1'b0; in_tt = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    run_one(16'h0000, 16'h0000, 0, 4'h0, 1'b0, 1'b0);
    run_one(16'hFFFF, 16'h0000, 0, 4'h0, 1'b1, 1'b0);
    run_one(16'h8000, 16'h0001, 0, 4'hF, 1'b0, 1'b1);

    fam = '{16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00};
    foreach (fam[k]) begin
      ref_canon(fam[k], bt, bp, bm, bn);
      run_one(fam[k], 16'h00FF, bp, bm, bn, 1'b0);
    end

    // Reset in the middle of a scan.
    @(negedge clk);
    in_valid = 1'b1;
    in_tt    = 16'h6996;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midscan_reset");
    run_one(16'h0001, 16'h0001, 0, 4'h0, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      f = 16'($urandom);
      ref_canon(f, bt, bp, bm, bn);
      run_one(f, bt, bp, bm, bn, (t == 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
